mcenoc_apb_arbiter: RTL and testbench
=====================================

// Module: mcenoc_apb_arbiter
// PURPOSE
//  Shares one APB completer (shared UART, status regs) between NUM_REQ cores.
//  Requesters issue single 32-bit read/write requests; round-robin grant; one
//  APB transfer in flight at a time; completion pulse + response to the winner.
//  Sits between the per-core coregen slices and the system APB completer.
// PARAMETERS
//  NUM_REQ         16   number of requesting cores (>=1)
//  TIMEOUT_CYCLES  255  max ACCESS cycles before forced error (timeout build only)
// PORTS
//  clk          in   1           system clock
//  reset        in   1           synchronous, active-high reset
//  req_valid    in   NUM_REQ     request pending, held until req_done for that index
//  req_write    in   NUM_REQ     1=write, 0=read
//  req_addr     in   NUM_REQ*32  flattened, index i at [32*i+:32]
//  req_wdata    in   NUM_REQ*32  flattened write data
//  req_done     out  NUM_REQ     one-cycle completion pulse, one-hot
//  rsp_rdata    out  32          read data, valid while req_done!=0
//  rsp_err      out  1           pslverr/timeout, valid while req_done!=0
//  paddr        out  32          APB address
//  psel         out  1           APB select
//  penable      out  1           APB enable
//  pwrite       out  1           APB direction
//  pwdata       out  32          APB write data
//  pstrb        out  4           4'hF on write, 4'h0 on read
//  pprot        out  3           constant 3'b000
//  pready       in   1           APB completer ready
//  prdata       in   32          APB read data
//  pslverr      in   1           APB error
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0; psel, penable, pwrite, req_done, rsp_err = 0;
//   paddr, pwdata, rsp_rdata = 0. Reset mid-transfer: psel/penable low next edge, no req_done.
//  FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
//   IDLE: if any req_valid, pick grant g = first set index at/after pointer (wrap
//    mod NUM_REQ); register g, paddr, pwdata, pwrite from index g; go SETUP.
//   SETUP: psel=1, penable=0; go ACCESS unconditionally.
//   ACCESS: psel=1, penable=1; on pready: capture prdata (reads; 0 on writes) and
//    pslverr, go DONE. Stay in ACCESS while pready=0.
//   DONE: psel=penable=0; req_done[g]=1 one cycle; pointer = (g+1) mod NUM_REQ; go IDLE.
//  Latency: request in IDLE at cycle 0 -> SETUP c1 -> ACCESS c2 -> req_done at c(k+1)
//   where k>=2 is the pready cycle; min 4 cycles/transfer, no back-to-back overlap.
//  Requester drops req_valid the cycle after req_done; IDLE then samples clean valids.
//  APB signals paddr/pwrite/pwdata stable from SETUP through the pready cycle.
//  req_valid toggled by a non-granted requester has no effect on the current transfer.
//  Fairness: pointer update only on DONE; each active requester served within NUM_REQ grants.
//  NUM_REQ=1: pointer fixed at 0, grant always 0.
// CONFIGURATION
//  MCENOC_APB_TIMEOUT_EN defined: 8-bit+ counter cleared on SETUP, increments each
//   ACCESS cycle without pready; reaching TIMEOUT_CYCLES -> DONE with rsp_err=1,
//   rsp_rdata=0, psel/penable drop. pready on the same cycle wins (normal completion).
//  Undefined: no counter; ACCESS waits indefinitely for pready.
// STRUCTURE
//  mcenoc_apb_pkg: arb_state_t enum {IDLE,SETUP,ACCESS,DONE}; APB_DW=32, APB_AW=32,
//   PSTRB_ALL=4'hF constants.
//  Sub-module mcenoc_rr_arbiter (req vector + pointer -> one-hot grant + index, combinational).
// TESTING
//  Single read: req_valid[0]=1, addr 0x10, prdata=0xDEADBEEF pready in c2 ->
//   psel c1-c2, penable c2, req_done[0] c3, rsp_rdata=0xDEADBEEF, rsp_err=0.
//  Contention: req_valid[0],[2],[5] together, pointer 0 -> grants 0,2,5 in order;
//   re-raise 0 and 5 after -> grant 5 before 0.
//  Wait states: pready low 3 ACCESS cycles, write 0x55 -> paddr/pwdata/pwrite stable,
//   pstrb=4'hF, req_done 1 cycle after pready.
//  pslverr=1 on read -> rsp_err=1 with req_done; next transfer rsp_err=0.
//  Reset in ACCESS -> psel=penable=0 next cycle, no req_done, next grant from index 0.
//  Timeout build, pready held 0 -> DONE after TIMEOUT_CYCLES ACCESS cycles, rsp_err=1,
//   rsp_rdata=0; non-timeout build stays in ACCESS.

Source files
------------

// File: rtl/mcenoc_apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcenoc_apb_pkg
//  Description : Shared types and constants for the multi-core APB arbiter:
//                arbiter state encoding, APB bus widths, the full write strobe
//                and the grant index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcenoc_apb_pkg;

   localparam int          APB_DW    = 32;
   localparam int          APB_AW    = 32;
   localparam logic [3:0]  PSTRB_ALL = 4'hF;

   localparam logic [1:0]  ST_IDLE   = 2'd0;
   localparam logic [1:0]  ST_SETUP  = 2'd1;
   localparam logic [1:0]  ST_ACCESS = 2'd2;
   localparam logic [1:0]  ST_DONE   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      SETUP  = ST_SETUP,
      ACCESS = ST_ACCESS,
      DONE   = ST_DONE
   } arb_state_t;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mcenoc_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mcenoc_rr_arbiter
//  Description : Combinational round-robin pick. Returns the first asserted
//                request at or after the pointer, wrapping modulo N.
//  Ports       : i_req   [N-1:0]  request vector
//                i_ptr   [IW-1:0] priority pointer (highest priority index)
//                o_grant [N-1:0]  one-hot grant (zero when no request)
//                o_idx   [IW-1:0] binary index of the grant
//                o_any            at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module mcenoc_rr_arbiter
   import mcenoc_apb_pkg::*;
#(
   parameter int N  = 16,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      // Scan N positions starting at the pointer; first hit wins.
      for (int j = 0; j < N; j++) begin
         int k;
         k = int'(i_ptr) + j;
         if (k >= N) k = k - N;
         if (!o_any && i_req[k]) begin
            o_any      = 1'b1;
            o_idx      = IW'(k);
            o_grant[k] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mcenoc_apb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mcenoc_apb_arbiter
//  Description : Shares one APB completer between NUM_REQ cores. Single 32-bit
//                read/write requests, round-robin grant, one transfer in
//                flight, one-cycle one-hot completion pulse with response.
//  Config      : MCENOC_APB_TIMEOUT_EN - when defined, an ACCESS phase lasting
//                TIMEOUT_CYCLES cycles without pready is ended with rsp_err=1.
//  Ports       : clk, reset (sync, active-high)
//                req_valid/req_write [NUM_REQ], req_addr/req_wdata [NUM_REQ*32]
//                req_done [NUM_REQ], rsp_rdata [32], rsp_err
//                APB: paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
//                     pready, prdata, pslverr
//  Revision    : 1.0 - initial release
// ============================================================================
module mcenoc_apb_arbiter
   import mcenoc_apb_pkg::*;
#(
   parameter int NUM_REQ        = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*APB_AW-1:0] req_addr,
   input  logic [NUM_REQ*APB_DW-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_done,
   output logic [APB_DW-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic [APB_AW-1:0]         paddr,
   output logic                      psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [APB_DW-1:0]         pwdata,
   output logic [3:0]                pstrb,
   output logic [2:0]                pprot,
   input  logic                      pready,
   input  logic [APB_DW-1:0]         prdata,
   input  logic                      pslverr
);

   localparam int IW = idx_width(NUM_REQ);

   if (NUM_REQ < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("mcenoc_apb_arbiter: NUM_REQ and TIMEOUT_CYCLES must be >= 1");
   end

   arb_state_t          r_state;
   logic [IW-1:0]       r_ptr;
   logic [IW-1:0]       r_gidx;
   logic [NUM_REQ-1:0]  r_gsel;
   logic [APB_AW-1:0]   r_paddr;
   logic [APB_DW-1:0]   r_pwdata;
   logic                r_pwrite;
   logic [APB_DW-1:0]   r_rdata;
   logic                r_err;

   logic [NUM_REQ-1:0]  w_grant;
   logic [IW-1:0]       w_idx;
   logic                w_any;

`ifdef MCENOC_APB_TIMEOUT_EN
   localparam int TCW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TCW-1:0]      r_tcnt;
`endif

   mcenoc_rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_ptr    <= '0;
         r_gidx   <= '0;
         r_gsel   <= '0;
         r_paddr  <= '0;
         r_pwdata <= '0;
         r_pwrite <= 1'b0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
`ifdef MCENOC_APB_TIMEOUT_EN
         r_tcnt   <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               // Request fields are latched here so the APB phase stays
               // stable regardless of what the requesters do afterwards.
               if (w_any) begin
                  r_gidx   <= w_idx;
                  r_gsel   <= w_grant;
                  r_paddr  <= req_addr[APB_AW*int'(w_idx) +: APB_AW];
                  r_pwdata <= req_wdata[APB_DW*int'(w_idx) +: APB_DW];
                  r_pwrite <= req_write[w_idx];
                  r_state  <= SETUP;
               end
            end
            SETUP: begin
`ifdef MCENOC_APB_TIMEOUT_EN
               r_tcnt  <= '0;
`endif
               r_state <= ACCESS;
            end
            ACCESS: begin
               // pready has priority over an expiring timeout.
               if (pready) begin
                  r_rdata <= r_pwrite ? '0 : prdata;
                  r_err   <= pslverr;
                  r_state <= DONE;
               end
`ifdef MCENOC_APB_TIMEOUT_EN
               else if (r_tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
                  r_rdata <= '0;
                  r_err   <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_tcnt  <= r_tcnt + TCW'(1);
               end
`endif
            end
            DONE: begin
               // Next search starts just past the winner.
               if (r_gidx == IW'(NUM_REQ - 1)) r_ptr <= '0;
               else                            r_ptr <= r_gidx + IW'(1);
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign psel      = (r_state == SETUP) || (r_state == ACCESS);
   assign penable   = (r_state == ACCESS);
   assign paddr     = r_paddr;
   assign pwrite    = r_pwrite;
   assign pwdata    = r_pwdata;
   assign pstrb     = r_pwrite ? PSTRB_ALL : 4'h0;
   assign pprot     = 3'b000;
   assign req_done  = (r_state == DONE) ? r_gsel : '0;
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mcenoc_apb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcenoc_apb_arbiter
//  Description : Directed self-checking bench for mcenoc_apb_arbiter with
//                hand-computed expectations (NUM_REQ=8, TIMEOUT_CYCLES=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcenoc_apb_arbiter;

   localparam int N  = 8;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid, req_write;
   logic [N*32-1:0] req_addr, req_wdata;
   logic [N-1:0]    req_done;
   logic [31:0]     rsp_rdata;
   logic            rsp_err;
   logic [31:0]     paddr;
   logic            psel, penable, pwrite;
   logic [31:0]     pwdata;
   logic [3:0]      pstrb;
   logic [2:0]      pprot;
   logic            pready;
   logic [31:0]     prdata;
   logic            pslverr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mcenoc_apb_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_done  (req_done),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .paddr     (paddr),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .pprot     (pprot),
      .pready    (pready),
      .prdata    (prdata),
      .pslverr   (pslverr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transfer for requester idx, starting from IDLE with req_valid set.
   task automatic xfer(input int idx, input int waits, input logic [31:0] rd, input logic err);
      logic [31:0]  a, wd;
      logic         wr;
      logic [N-1:0] e;
      a  = req_addr[32*idx +: 32];
      wd = req_wdata[32*idx +: 32];
      wr = req_write[idx];
      e  = '0;
      e[idx] = 1'b1;
      step();                                   // SETUP
      chk("setup_psel", psel, 1);
      chk("setup_penable", penable, 0);
      chk("setup_paddr", paddr, a);
      chk("setup_pwrite", pwrite, wr);
      chk("setup_pwdata", pwdata, wd);
      chk("setup_pstrb", pstrb, wr ? 4'hF : 4'h0);
      step();                                   // first ACCESS cycle
      for (int w = 0; w < waits; w++) begin
         chk("wait_penable", penable, 1);
         chk("wait_paddr", paddr, a);
         chk("wait_pwdata", pwdata, wd);
         chk("wait_pwrite", pwrite, wr);
         chk("wait_done", req_done, 0);
         step();
      end
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      pready  = 1'b1;
      prdata  = rd;
      pslverr = err;
      step();                                   // DONE
      pready  = 1'b0;
      pslverr = 1'b0;
      chk("done_vec", req_done, e);
      chk("done_rdata", rsp_rdata, wr ? 32'h0 : rd);
      chk("done_err", rsp_err, err);
      chk("done_psel", psel, 0);
      chk("done_penable", penable, 0);
      req_valid[idx] = 1'b0;
      step();                                   // IDLE
      chk("idle_done", req_done, 0);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_write = 8'b0000_1000;
      pready    = 1'b0;
      prdata    = '0;
      pslverr   = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_addr[32*i +: 32]  = 32'h1000 + 32'(16*i);
         req_wdata[32*i +: 32] = 32'hA000_0000 + 32'(i);
      end
      req_addr[31:0]    = 32'h10;
      req_wdata[127:96] = 32'h55;

      repeat (2) step();
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_pwrite", pwrite, 0);
      chk("rst_done", req_done, 0);
      chk("rst_err", rsp_err, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_pprot", pprot, 0);
      reset = 1'b0;
      step();

      // single read, pready in first ACCESS cycle
      req_valid[0] = 1'b1;
      xfer(0, 0, 32'hDEAD_BEEF, 1'b0);                 // ptr -> 1

      // write with three wait states
      req_valid[3] = 1'b1;
      xfer(3, 3, 32'hCAFE_0003, 1'b0);                 // ptr -> 4

      // slave error on a read, then a clean read
      req_valid[6] = 1'b1;
      xfer(6, 1, 32'h0BAD_0006, 1'b1);                 // ptr -> 7
      req_valid[7] = 1'b1;
      xfer(7, 0, 32'h7777_7777, 1'b0);                 // ptr -> 0

      // contention from pointer 0
      req_valid[0] = 1'b1;
      req_valid[2] = 1'b1;
      req_valid[5] = 1'b1;
      xfer(0, 0, 32'h0000_00A0, 1'b0);                 // ptr -> 1
      xfer(2, 0, 32'h0000_00A2, 1'b0);                 // ptr -> 3
      req_valid[0] = 1'b1;
      xfer(5, 0, 32'h0000_00A5, 1'b0);                 // ptr -> 6
      xfer(0, 0, 32'h0000_00B0, 1'b0);                 // ptr -> 1

      // reset during ACCESS
      req_valid[4] = 1'b1;
      step();
      chk("rst_mid_setup_paddr", paddr, 32'h1040);
      step();
      chk("rst_mid_access", penable, 1);
      reset = 1'b1;
      step();
      chk("rst_mid_psel", psel, 0);
      chk("rst_mid_penable", penable, 0);
      chk("rst_mid_done", req_done, 0);
      reset = 1'b0;
      req_valid[0] = 1'b1;
      xfer(0, 0, 32'h1111_0000, 1'b0);                 // pointer back at 0
      xfer(4, 0, 32'h4444_0004, 1'b0);                 // ptr -> 5

      // completer never ready; grant wraps from pointer 5 to index 2
      req_valid[2] = 1'b1;
      prdata = 32'h1234_5678;
      step();
      chk("hang_paddr", paddr, 32'h1020);
      step();
`ifdef MCENOC_APB_TIMEOUT_EN
      for (int i = 1; i < TO; i++) begin
         chk("to_penable", penable, 1);
         chk("to_done", req_done, 0);
         step();
      end
      chk("to_last_penable", penable, 1);
      step();
      chk("to_done_vec", req_done, 8'b0000_0100);
      chk("to_err", rsp_err, 1);
      chk("to_rdata", rsp_rdata, 0);
      chk("to_psel", psel, 0);
`else
      for (int i = 0; i < 20; i++) begin
         chk("hold_penable", penable, 1);
         chk("hold_done", req_done, 0);
         step();
      end
      pready = 1'b1;
      step();
      pready = 1'b0;
      chk("hold_done_vec", req_done, 8'b0000_0100);
      chk("hold_rdata", rsp_rdata, 32'h1234_5678);
      chk("hold_err", rsp_err, 0);
`endif
      req_valid[2] = 1'b0;
      step();
      chk("end_done", req_done, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
